// File: rtl/timeshared_channel_mux_if.sv
// rtl/timeshared_channel_mux_if.sv - channel inputs and serialised output of the TDM mux
interface timeshared_channel_mux_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 1
);
  localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic                     en;
  logic                     skip_mode;
  logic [NUM_CH-1:0]        ch_mask;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [DATA_W-1:0]        out;
  logic [CH_W-1:0]          out_ch;
  logic                     out_valid;
  logic                     frame_start;

  modport master (
    output en, skip_mode, ch_mask, data_in,
    input  out, out_ch, out_valid, frame_start
  );

  modport slave (
    input  en, skip_mode, ch_mask, data_in,
    output out, out_ch, out_valid, frame_start
  );
endinterface

// File: rtl/timeshared_channel_mux.sv
// rtl/timeshared_channel_mux.sv - serialises NUM_CH parallel inputs onto one registered output
// Each slot holds a channel for DWELL edges; skip mode jumps over masked channels.
module timeshared_channel_mux #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 1,
  parameter int DWELL  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  timeshared_channel_mux_if.slave bus
);
  localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW_W = ($clog2(DWELL) > 1) ? $clog2(DWELL) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [DW_W-1:0] LAST_DW = DW_W'(DWELL - 1);

  logic [CH_W-1:0]   sel_q, sel_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              fresh_q, fresh_d;

  logic [CH_W-1:0]   lowest, eff_sel, nxt_skip, nxt, head;
  logic              any_en, sel_masked;

  always_comb begin
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) lowest = CH_W'(i);
    end
  end

  // Right after reset in skip mode, start at the lowest enabled channel rather than ch0.
  assign any_en  = |bus.ch_mask;
  assign eff_sel = (fresh_q && bus.skip_mode) ? lowest : sel_q;

  // Circular search; k == NUM_CH lands back on eff_sel so a lone enabled channel holds.
  always_comb begin
    logic found;
    int   idx;
    nxt_skip = eff_sel;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(eff_sel) + k) % NUM_CH;
      if (!found && bus.ch_mask[idx]) begin
        nxt_skip = CH_W'(idx);
        found    = 1'b1;
      end
    end
  end

  assign nxt        = bus.skip_mode ? nxt_skip
                    : ((eff_sel == LAST_CH) ? '0 : eff_sel + CH_W'(1));
  assign head       = bus.skip_mode ? lowest : '0;
  assign sel_masked = bus.skip_mode && !bus.ch_mask[eff_sel];

  always_comb begin
    sel_d         = sel_q;
    dwell_d       = dwell_q;
    out_d         = out_q;
    out_ch_d      = out_ch_q;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    fresh_d       = fresh_q;
    if (bus.en) begin
      out_d         = bus.data_in[eff_sel*DATA_W +: DATA_W];
      out_ch_d      = eff_sel;
      out_valid_d   = bus.ch_mask[eff_sel];
      frame_start_d = any_en && (dwell_q == '0) && (eff_sel == head);
      fresh_d       = 1'b0;
      if (sel_masked || dwell_q == LAST_DW) begin
        dwell_d = '0;
        sel_d   = nxt;
      end else begin
        dwell_d = dwell_q + DW_W'(1);
        sel_d   = eff_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q         <= '0;
      dwell_q       <= '0;
      out_q         <= '0;
      out_ch_q      <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      fresh_q       <= 1'b1;
    end else begin
      sel_q         <= sel_d;
      dwell_q       <= dwell_d;
      out_q         <= out_d;
      out_ch_q      <= out_ch_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      fresh_q       <= fresh_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.out_ch      = out_ch_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
endmodule
